down_timer_32bits: RTL and testbench
====================================

// Module: down_timer_32bits
// PURPOSE
//   Loadable down-counting timer: the count-down counterpart of counter_32bits.
//   Counts from a programmed value to zero at a prescaled tick rate and emits a one-cycle terminal-count pulse.
//   Runs one-shot or auto-reload (periodic). Sits beside counter_32bits as the timeout/period source for control logic.
// PARAMETERS
//   WIDTH      32  counter and load-value width
//   PRESCALE   1   enabled clk cycles per tick; legal range >= 1
// PORTS
//   clk          in   1      single clock, rising edge
//   p_reset      in   1      reset: asynchronous, active-high
//   en           in   1      tick gate; 0 freezes the prescaler and the count
//   load         in   1      load load_val into the count and the reload register
//   load_val     in   WIDTH  value captured on load
//   start        in   1      start or resume counting
//   stop         in   1      halt counting and hold the count
//   auto_reload  in   1      1 = periodic, 0 = one-shot
//   cnt_out      out  WIDTH  current count
//   tc_pulse     out  1      one-cycle terminal-count strobe (registered)
//   busy         out  1      high while state == RUN
// BEHAVIOUR
//   Reset (async, p_reset=1): cnt_out=0, reload_reg=0, prescaler=0, tc_pulse=0, busy=0, state=IDLE.
//     Applies immediately, including mid-RUN. No pulse is generated on reset exit.
//   States:
//     IDLE     stopped; cnt_out holds
//     RUN      counting
//     EXPIRED  one-shot finished; cnt_out=0
//   Input priority per edge: load > stop > start > tick.
//   load, any state:
//     cnt_out<=load_val, reload_reg<=load_val, prescaler<=0, state->IDLE.
//     Suppresses a coincident tick and tc_pulse.
//   stop in RUN:
//     state->IDLE, prescaler<=0, cnt_out holds.
//     Suppresses a coincident terminal tick; no tc_pulse.
//   start in IDLE:
//     cnt_out!=0 -> RUN, resuming from cnt_out with prescaler=0.
//     cnt_out==0 -> ignored.
//   start in EXPIRED:
//     reload_reg!=0 -> cnt_out<=reload_reg, RUN.
//     reload_reg==0 -> ignored.
//   start in RUN: ignored.
//   Tick, RUN && en:
//     Prescaler counts 0..PRESCALE-1; the tick fires on the edge where prescaler==PRESCALE-1,
//     and the prescaler returns to 0.
//     If start is sampled at edge N and en stays high, the first decrement is at edge N+PRESCALE.
//   Decrement on tick:
//     cnt_out>1: cnt_out<=cnt_out-1.
//     cnt_out==1 && auto_reload: cnt_out<=reload_reg, tc_pulse<=1, stay RUN.
//       Period = reload_reg ticks; cnt_out never shows 0.
//     cnt_out==1 && !auto_reload: cnt_out<=0, tc_pulse<=1, state->EXPIRED.
//       busy falls on the same edge.
//   tc_pulse is high for exactly one cycle per terminal tick.
//     With PRESCALE=1 and reload=1 it stays high every cycle, which is legal.
//   Arithmetic is unsigned. No wrap: 0 is never decremented. load_val=all-ones is legal.
//   en=0 in RUN: prescaler and cnt_out frozen, busy stays 1, state stays RUN.
//   auto_reload is sampled only at the terminal tick; changing it mid-run is legal.
// STRUCTURE
//   Shared include counter_defs.vh: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_EXPIRED=2'd2.
//   Sub-module tick_prescaler (params PRESCALE; ports clk, p_reset, en, clr, tick):
//     counter width $clog2(PRESCALE), minimum 1; tick is combinational at terminal.
//     The top holds the FSM, the count and the reload registers.
// TESTING
//   1 Mid-RUN reset: p_reset=1 for 3 cycles while cnt_out=7 -> all outputs 0 immediately, IDLE.
//     After release, start alone is ignored.
//   2 One-shot, PRESCALE=1, en=1: load 5, start -> cnt_out 5,4,3,2,1,0.
//     tc_pulse high only on the edge where cnt_out becomes 0; busy drops on that edge; state EXPIRED.
//   3 auto_reload=1: load 3, start -> cnt_out 3,2,1,3,2,1,...; tc_pulse every 3rd cycle; busy stays 1.
//   4 PRESCALE=4: load 2, start, en=1 -> decrement every 4 cycles.
//     Drop en for 5 cycles mid-run -> cnt_out and prescaler frozen, then resume with no lost ticks.
//   5 Collisions at cnt_out=1 on a terminal tick:
//     load 9 -> cnt_out=9, IDLE, no tc_pulse.
//     Separately, stop -> cnt_out=1, IDLE, no tc_pulse; a later start gives tc after 1 tick.
//   6 load 0xFFFFFFFF, start -> next tick 0xFFFFFFFE.
//     load 0 then start -> ignored, busy=0.
//     EXPIRED + start with reload 4 -> RUN from 4.

Source files
------------

// File: rtl/down_timer_32bits_pkg.sv
// Shared definitions for the down-counting timer.
//   state_e : timer FSM states (IDLE = stopped, RUN = counting,
//             EXPIRED = one-shot finished with the count at zero).
package down_timer_32bits_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

endpackage : down_timer_32bits_pkg

// File: rtl/tick_prescaler.sv
// Prescaler for the down timer: counts enabled cycles 0..PRESCALE-1 and
// raises tick (combinational) during the cycle the counter sits at its
// terminal value, so the owner acts on the same edge the counter wraps.
// Ports:
//   clk      in  rising-edge clock
//   p_reset  in  asynchronous active-high reset
//   en       in  advance the counter this cycle
//   clr      in  force the counter back to 0 (dominates en)
//   tick     out high while en is high and the counter is at PRESCALE-1
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic p_reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_q, pre_d;
  logic          at_term;

  assign at_term = (pre_q == TERM);
  assign tick    = en && at_term;

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = at_term ? '0 : pre_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge p_reset) begin
    if (p_reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule : tick_prescaler

// File: rtl/down_timer_32bits.sv
// Loadable down-counting timer with prescaled tick, one-shot or
// auto-reload operation and a registered one-cycle terminal-count strobe.
// Ports:
//   clk          in   rising-edge clock
//   p_reset      in   asynchronous active-high reset
//   en           in   tick gate; 0 freezes prescaler and count
//   load         in   load load_val into count and reload register
//   load_val     in   value captured on load
//   start        in   start / resume counting
//   stop         in   halt counting, hold count
//   auto_reload  in   1 = periodic, 0 = one-shot (sampled at terminal tick)
//   cnt_out      out  current count
//   tc_pulse     out  terminal-count strobe
//   busy         out  high while counting (RUN)
module down_timer_32bits
  import down_timer_32bits_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             p_reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc_pulse,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             running;

  assign running = (state_q == ST_RUN);

  // Prescaler is held at 0 outside RUN and on load/stop, so every start
  // or resume sees a full PRESCALE-cycle wait before the first decrement.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .p_reset (p_reset),
    .en      (en && running),
    .clr     (load || stop || !running),
    .tick    (tick)
  );

  // Priority: load > stop > start > tick.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      cnt_d    = load_val;
      reload_d = load_val;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && (cnt_q != '0)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            if (cnt_q > WIDTH'(1)) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else if (cnt_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = '0;
                state_d = ST_EXPIRED;
              end
            end
          end
        end
        ST_EXPIRED: begin
          if (start && (reload_q != '0)) begin
            cnt_d   = reload_q;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge p_reset) begin
    if (p_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign cnt_out  = cnt_q;
  assign tc_pulse = tc_q;
  assign busy     = running;

endmodule : down_timer_32bits

// File: tb/tb_down_timer_32bits.sv
module tb_down_timer_32bits;

  logic        clk = 1'b0;
  logic        p_reset;
  logic        en;
  logic        load;
  logic [31:0] load_val;
  logic        start;
  logic        stop;
  logic        auto_reload;

  logic [31:0] cnt1, cnt4;
  logic        tc1, tc4, busy1, busy4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ld;
    logic [31:0] lv;
    logic        st;
    logic        sp;
    logic        ar;
    logic        en;
    logic [31:0] cnt;
    logic        tc;
    logic        busy;
  } row_t;

  typedef struct {
    logic [31:0] cnt;
    logic        tc;
    logic        busy;
  } exp_t;

  row_t stim[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  down_timer_32bits #(.WIDTH(32), .PRESCALE(1)) dut1 (
    .clk(clk), .p_reset(p_reset), .en(en), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .cnt_out(cnt1), .tc_pulse(tc1), .busy(busy1)
  );

  down_timer_32bits #(.WIDTH(32), .PRESCALE(4)) dut4 (
    .clk(clk), .p_reset(p_reset), .en(en), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .cnt_out(cnt4), .tc_pulse(tc4), .busy(busy4)
  );

  function automatic void add(input logic ld, input logic [31:0] lv, input logic st,
                              input logic sp, input logic ar, input logic e,
                              input logic [31:0] c, input logic t, input logic b);
    row_t r;
    r.ld = ld; r.lv = lv; r.st = st; r.sp = sp; r.ar = ar; r.en = e;
    r.cnt = c; r.tc = t; r.busy = b;
    stim.push_back(r);
  endfunction

  task automatic drive(input row_t r);
    load = r.ld; load_val = r.lv; start = r.st; stop = r.sp;
    auto_reload = r.ar; en = r.en;
  endtask

  task automatic test_reset();
    row_t r;
    exp_t e;
    int   cyc;
    p_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cnt1 !== 32'd0 || tc1 !== 1'b0 || busy1 !== 1'b0 ||
        cnt4 !== 32'd0 || tc4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: got cnt1=%h tc1=%b busy1=%b cnt4=%h tc4=%b busy4=%b, expected all 0",
               cnt1, tc1, busy1, cnt4, tc4, busy4);
    end
    p_reset = 1'b0;
    // load 7, start with en=0 so the count stays at 7 in RUN
    add(1, 32'd7, 0, 0, 0, 0, 32'd7, 0, 0);
    add(0, 32'd0, 1, 0, 0, 0, 32'd7, 0, 1);
    cyc = 0;
    while (stim.size() > 0) begin
      r = stim.pop_front();
      drive(r);
      sb.push_back('{r.cnt, r.tc, r.busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (cnt1 !== e.cnt || tc1 !== e.tc || busy1 !== e.busy) begin
        errors++;
        $display("FAIL reset_setup cyc %0d: got cnt=%h tc=%b busy=%b, expected cnt=%h tc=%b busy=%b",
                 cyc, cnt1, tc1, busy1, e.cnt, e.tc, e.busy);
      end
      cyc++;
    end
    start = 1'b0;
    #2 p_reset = 1'b1;
    #1;
    checks++;
    if (cnt1 !== 32'd0 || tc1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got cnt=%h tc=%b busy=%b, expected cnt=0 tc=0 busy=0",
               cnt1, tc1, busy1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (cnt1 !== 32'd0 || tc1 !== 1'b0 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold %0d: got cnt=%h tc=%b busy=%b, expected cnt=0 tc=0 busy=0",
                 i, cnt1, tc1, busy1);
      end
    end
    p_reset = 1'b0;
    // start alone after reset: count is 0, so it must be ignored
    add(0, 32'd0, 1, 0, 0, 1, 32'd0, 0, 0);
    add(0, 32'd0, 0, 0, 0, 1, 32'd0, 0, 0);
    cyc = 0;
    while (stim.size() > 0) begin
      r = stim.pop_front();
      drive(r);
      sb.push_back('{r.cnt, r.tc, r.busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (cnt1 !== e.cnt || tc1 !== e.tc || busy1 !== e.busy) begin
        errors++;
        $display("FAIL reset_exit cyc %0d: got cnt=%h tc=%b busy=%b, expected cnt=%h tc=%b busy=%b",
                 cyc, cnt1, tc1, busy1, e.cnt, e.tc, e.busy);
      end
      cyc++;
    end
  endtask

  task automatic test_oneshot();
    row_t r;
    exp_t e;
    int   cyc = 0;
    add(1, 32'd5, 0, 0, 0, 1, 32'd5, 0, 0);
    add(0, 32'd0, 1, 0, 0, 1, 32'd5, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd4, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd3, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd2, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd1, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd0, 1, 0);
    add(0, 32'd0, 0, 0, 0, 1, 32'd0, 0, 0);
    // EXPIRED + start reloads 5; then stop holds
    add(0, 32'd0, 1, 0, 0, 1, 32'd5, 0, 1);
    add(0, 32'd0, 0, 1, 0, 1, 32'd5, 0, 0);
    while (stim.size() > 0) begin
      r = stim.pop_front();
      drive(r);
      sb.push_back('{r.cnt, r.tc, r.busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (cnt1 !== e.cnt || tc1 !== e.tc || busy1 !== e.busy) begin
        errors++;
        $display("FAIL oneshot cyc %0d: got cnt=%h tc=%b busy=%b, expected cnt=%h tc=%b busy=%b",
                 cyc, cnt1, tc1, busy1, e.cnt, e.tc, e.busy);
      end
      cyc++;
    end
  endtask

  task automatic test_auto_reload();
    row_t r;
    exp_t e;
    int   cyc = 0;
    add(1, 32'd3, 0, 0, 1, 1, 32'd3, 0, 0);
    add(0, 32'd0, 1, 0, 1, 1, 32'd3, 0, 1);
    add(0, 32'd0, 0, 0, 1, 1, 32'd2, 0, 1);
    add(0, 32'd0, 0, 0, 1, 1, 32'd1, 0, 1);
    add(0, 32'd0, 0, 0, 1, 1, 32'd3, 1, 1);
    add(0, 32'd0, 1, 0, 1, 1, 32'd2, 0, 1);  // start in RUN ignored
    add(0, 32'd0, 0, 0, 1, 1, 32'd1, 0, 1);
    add(0, 32'd0, 0, 0, 1, 1, 32'd3, 1, 1);
    add(0, 32'd0, 0, 0, 1, 1, 32'd2, 0, 1);
    add(0, 32'd0, 0, 1, 1, 1, 32'd2, 0, 0);
    // reload = 1: tc high every cycle
    add(1, 32'd1, 0, 0, 1, 1, 32'd1, 0, 0);
    add(0, 32'd0, 1, 0, 1, 1, 32'd1, 0, 1);
    add(0, 32'd0, 0, 0, 1, 1, 32'd1, 1, 1);
    add(0, 32'd0, 0, 0, 1, 1, 32'd1, 1, 1);
    add(0, 32'd0, 0, 0, 1, 1, 32'd1, 1, 1);
    add(0, 32'd0, 0, 1, 0, 1, 32'd1, 0, 0);
    while (stim.size() > 0) begin
      r = stim.pop_front();
      drive(r);
      sb.push_back('{r.cnt, r.tc, r.busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (cnt1 !== e.cnt || tc1 !== e.tc || busy1 !== e.busy) begin
        errors++;
        $display("FAIL auto_reload cyc %0d: got cnt=%h tc=%b busy=%b, expected cnt=%h tc=%b busy=%b",
                 cyc, cnt1, tc1, busy1, e.cnt, e.tc, e.busy);
      end
      cyc++;
    end
  endtask

  task automatic test_prescale();
    row_t r;
    exp_t e;
    int   cyc = 0;
    add(1, 32'd2, 0, 0, 0, 1, 32'd2, 0, 0);
    add(0, 32'd0, 1, 0, 0, 1, 32'd2, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd2, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd2, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd2, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd1, 0, 1);  // start edge + 4
    add(0, 32'd0, 0, 0, 0, 1, 32'd1, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd1, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 32'd0, 0, 0, 0, 0, 32'd1, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd1, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd0, 1, 0);  // 4th enabled cycle since last tick
    add(0, 32'd0, 0, 0, 0, 1, 32'd0, 0, 0);
    while (stim.size() > 0) begin
      r = stim.pop_front();
      drive(r);
      sb.push_back('{r.cnt, r.tc, r.busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (cnt4 !== e.cnt || tc4 !== e.tc || busy4 !== e.busy) begin
        errors++;
        $display("FAIL prescale cyc %0d: got cnt=%h tc=%b busy=%b, expected cnt=%h tc=%b busy=%b",
                 cyc, cnt4, tc4, busy4, e.cnt, e.tc, e.busy);
      end
      cyc++;
    end
  endtask

  task automatic test_collisions();
    row_t r;
    exp_t e;
    int   cyc = 0;
    add(1, 32'd2, 0, 0, 0, 1, 32'd2, 0, 0);
    add(0, 32'd0, 1, 0, 0, 1, 32'd2, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd1, 0, 1);
    add(1, 32'd9, 0, 0, 0, 1, 32'd9, 0, 0);  // load beats terminal tick
    add(0, 32'd0, 0, 0, 0, 1, 32'd9, 0, 0);
    add(1, 32'd2, 0, 0, 0, 1, 32'd2, 0, 0);
    add(0, 32'd0, 1, 0, 0, 1, 32'd2, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd1, 0, 1);
    add(0, 32'd0, 0, 1, 0, 1, 32'd1, 0, 0);  // stop beats terminal tick
    add(0, 32'd0, 0, 0, 0, 1, 32'd1, 0, 0);
    add(0, 32'd0, 1, 0, 0, 1, 32'd1, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd0, 1, 0);
    add(0, 32'd0, 0, 0, 0, 1, 32'd0, 0, 0);
    while (stim.size() > 0) begin
      r = stim.pop_front();
      drive(r);
      sb.push_back('{r.cnt, r.tc, r.busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (cnt1 !== e.cnt || tc1 !== e.tc || busy1 !== e.busy) begin
        errors++;
        $display("FAIL collision cyc %0d: got cnt=%h tc=%b busy=%b, expected cnt=%h tc=%b busy=%b",
                 cyc, cnt1, tc1, busy1, e.cnt, e.tc, e.busy);
      end
      cyc++;
    end
  endtask

  task automatic test_boundaries();
    row_t r;
    exp_t e;
    int   cyc = 0;
    add(1, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    add(0, 32'd0, 1, 0, 0, 1, 32'hFFFF_FFFF, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 1);
    add(1, 32'd0, 0, 0, 0, 1, 32'd0, 0, 0);
    add(0, 32'd0, 1, 0, 0, 1, 32'd0, 0, 0);  // start with count 0 ignored
    add(1, 32'd4, 0, 0, 0, 1, 32'd4, 0, 0);
    add(0, 32'd0, 1, 0, 0, 1, 32'd4, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd3, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd2, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd1, 0, 1);
    add(0, 32'd0, 0, 0, 0, 1, 32'd0, 1, 0);
    add(0, 32'd0, 1, 0, 0, 1, 32'd4, 0, 1);  // EXPIRED + start -> RUN from 4
    add(0, 32'd0, 0, 0, 0, 1, 32'd3, 0, 1);
    add(0, 32'd0, 0, 1, 0, 1, 32'd3, 0, 0);
    while (stim.size() > 0) begin
      r = stim.pop_front();
      drive(r);
      sb.push_back('{r.cnt, r.tc, r.busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (cnt1 !== e.cnt || tc1 !== e.tc || busy1 !== e.busy) begin
        errors++;
        $display("FAIL boundary cyc %0d: got cnt=%h tc=%b busy=%b, expected cnt=%h tc=%b busy=%b",
                 cyc, cnt1, tc1, busy1, e.cnt, e.tc, e.busy);
      end
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    p_reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
    start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_prescale();
    test_collisions();
    test_boundaries();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_down_timer_32bits
